forth_soc_top: RTL and testbench

Top level of a small Forth stack-machine SoC. It holds a single-cycle 16-bit dual-stack CPU with a unified instruction/data RAM, a memory-mapped 16-bit bidirectional GPIO port and an optional SPI-slave program loader. The CPU core is a sub-module instantiated as `cpu_top`; its RAM array is named `iram` so a bench can preload it hierarchically.

---
 rtl/forth_pkg.sv | 36 +++
 rtl/forth_soc_top_cpu.sv | 168 ++++++++++++++++
 rtl/forth_soc_top.sv | 124 ++++++++++++
 tb/tb_forth_soc_top.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/forth_pkg.sv
// Shared definitions for the Forth stack-machine SoC: opcode classes, ALU ops,
// stack-delta encodings and the memory-mapped I/O addresses.
package forth_pkg;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_CALL = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;

  localparam logic [1:0] SD_NONE = 2'b00;
  localparam logic [1:0] SD_PUSH = 2'b01;
  localparam logic [1:0] SD_POP  = 2'b11;

  localparam logic [15:0] IO_OUT_ADDR = 16'h0100;
  localparam logic [15:0] IO_DIR_ADDR = 16'h0101;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_INV   = 4'd5,
    ALU_EQZ   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_T     = 4'd8,
    ALU_N     = 4'd9,
    ALU_SHR   = 4'd10,
    ALU_SHL   = 4'd11,
    ALU_FETCH = 4'd12,
    ALU_STORE = 4'd13,
    ALU_R     = 4'd14,
    ALU_DEC   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/forth_soc_top_cpu.sv
// Single-cycle 16-bit dual-stack Forth CPU with unified instruction/data RAM (iram).
// Instructions are fetched combinationally from iram[pc]; stores land on the same edge.
module forth_cpu
  import forth_pkg::*;
#(
  parameter int RAM_WORDS   = 256,
  parameter int STACK_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_we,
  input  logic [$clog2(RAM_WORDS)-1:0] ld_addr,
  input  logic [15:0]                  ld_data,
  input  logic [15:0]                  io_rdata,
  output logic [15:0]                  io_addr,
  output logic                         io_we,
  output logic [15:0]                  io_wdata
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam logic [16:0]   RAM_TOP = 17'(RAM_WORDS);
  localparam logic [SW-1:0] SP_ONE  = SW'(1);

  logic [15:0]   iram [RAM_WORDS];
  logic [15:0]   dstk [STACK_DEPTH];
  logic [15:0]   rstk [STACK_DEPTH];

  logic [12:0]   pc, pc_nxt, pc_inc;
  logic [15:0]   t, n, r, t_nxt, n_nxt, r_nxt;
  logic [SW-1:0] dsp, rsp, dsp_nxt, rsp_nxt;
  logic [15:0]   ir, rd_data;
  logic          d_push, d_pop, r_push, r_pop, st_en, t_in_ram;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] tv,
                                      input logic [15:0] nv, input logic [15:0] rv,
                                      input logic [15:0] mv);
    logic signed [15:0] ts, ns;
    logic [15:0]        res;
    ts = tv;
    ns = nv;
    unique case (alu_op_e'(op))
      ALU_ADD:   res = nv + tv;
      ALU_SUB:   res = nv - tv;
      ALU_AND:   res = nv & tv;
      ALU_OR:    res = nv | tv;
      ALU_XOR:   res = nv ^ tv;
      ALU_INV:   res = ~tv;
      ALU_EQZ:   res = (tv == 16'h0000) ? 16'hFFFF : 16'h0000;
      ALU_SLT:   res = (ns < ts) ? 16'hFFFF : 16'h0000;
      ALU_T:     res = tv;
      ALU_N:     res = nv;
      ALU_SHR:   res = {1'b0, tv[15:1]};
      ALU_SHL:   res = {tv[14:0], 1'b0};
      ALU_FETCH: res = mv;
      ALU_STORE: res = tv + 16'd1;
      ALU_R:     res = rv;
      ALU_DEC:   res = tv - 16'd1;
    endcase
    return res;
  endfunction

  assign ir       = ({4'b0000, pc} < RAM_TOP) ? iram[pc[AW-1:0]] : 16'h0000;
  assign t_in_ram = ({1'b0, t} < RAM_TOP);
  assign rd_data  = t_in_ram ? iram[t[AW-1:0]] : io_rdata;

  assign io_addr  = t;
  assign io_wdata = n;
  assign io_we    = st_en && !t_in_ram && !rst;

  always_comb begin
    pc_inc  = pc + 13'd1;
    pc_nxt  = pc_inc;
    t_nxt   = t;
    n_nxt   = n;
    r_nxt   = r;
    dsp_nxt = dsp;
    rsp_nxt = rsp;
    d_push  = 1'b0;
    d_pop   = 1'b0;
    r_push  = 1'b0;
    r_pop   = 1'b0;
    st_en   = 1'b0;
    if (ir[15]) begin
      d_push = 1'b1;
      t_nxt  = {1'b0, ir[14:0]};
    end else begin
      unique case (ir[15:13])
        OP_ALU: begin
          t_nxt = alu(ir[11:8], t, n, r, rd_data);
          st_en = (ir[11:8] == ALU_STORE);
          case (ir[7:6])
            SD_PUSH: d_push = 1'b1;
            SD_POP:  d_pop  = 1'b1;
            SD_NONE: ;
            default: ;
          endcase
          case (ir[5:4])
            SD_PUSH: begin
              r_push = 1'b1;
              r_nxt  = ir[3] ? t : {3'b000, pc_inc};
            end
            SD_POP:  r_pop = 1'b1;
            SD_NONE: ;
            default: ;
          endcase
          if (ir[12]) pc_nxt = r[12:0];
        end
        OP_CALL: begin
          r_push = 1'b1;
          r_nxt  = {3'b000, pc_inc};
          pc_nxt = ir[12:0];
        end
        OP_JMP: pc_nxt = ir[12:0];
        OP_JZ: begin
          d_pop  = 1'b1;
          t_nxt  = n;
          pc_nxt = (t == 16'h0000) ? ir[12:0] : pc_inc;
        end
        default: ;
      endcase
    end
    // N is the cached second entry; the stack arrays hold everything below it
    if (d_push) begin
      n_nxt   = t;
      dsp_nxt = dsp + SP_ONE;
    end else if (d_pop) begin
      n_nxt   = dstk[dsp - SP_ONE];
      dsp_nxt = dsp - SP_ONE;
    end
    if (r_push) begin
      rsp_nxt = rsp + SP_ONE;
    end else if (r_pop) begin
      r_nxt   = rstk[rsp - SP_ONE];
      rsp_nxt = rsp - SP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      t   <= '0;
      n   <= '0;
      r   <= '0;
      dsp <= '0;
      rsp <= '0;
    end else begin
      pc  <= pc_nxt;
      t   <= t_nxt;
      n   <= n_nxt;
      r   <= r_nxt;
      dsp <= dsp_nxt;
      rsp <= rsp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (d_push) dstk[dsp] <= n;
    if (r_push) rstk[rsp] <= r;
  end

  // Loader writes win over CPU stores; a store under reset is aborted
  always_ff @(posedge clk) begin
    if (ld_we) iram[ld_addr] <= ld_data;
    else if (st_en && t_in_ram && !rst) iram[t[AW-1:0]] <= n;
  end

endmodule

// File: rtl/forth_soc_top.sv
// Forth SoC top: CPU core, memory-mapped GPIO with tri-state pins, and the
// optional SPI-slave program loader enabled by defining SPI_LOADER_EN.
module forth_soc_top
  import forth_pkg::*;
#(
  parameter int RAM_WORDS   = 256,
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nCS,
  input  logic        SCK,
  input  logic        MOSI,
  inout  wire  [15:0] pins
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [15:0]   gpio_out, gpio_dir;
  logic [15:0]   io_addr, io_wdata, io_rdata;
  logic          io_we;
  logic          ld_we, cpu_hold, cpu_rst;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;

  assign cpu_rst = reset | cpu_hold;

  forth_cpu #(
    .RAM_WORDS  (RAM_WORDS),
    .STACK_DEPTH(STACK_DEPTH)
  ) cpu_top (
    .clk     (clk),
    .rst     (cpu_rst),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .io_rdata(io_rdata),
    .io_addr (io_addr),
    .io_we   (io_we),
    .io_wdata(io_wdata)
  );

  always_comb begin
    io_rdata = 16'h0000;
    if (io_addr == IO_OUT_ADDR)      io_rdata = pins;
    else if (io_addr == IO_DIR_ADDR) io_rdata = gpio_dir;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_dir <= '0;
    end else if (io_we) begin
      if (io_addr == IO_OUT_ADDR)      gpio_out <= io_wdata;
      else if (io_addr == IO_DIR_ADDR) gpio_dir <= io_wdata;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_pin
    assign pins[i] = gpio_dir[i] ? gpio_out[i] : 1'bz;
  end

`ifdef SPI_LOADER_EN
  logic          cs_p0, cs_p1, sck_p0, sck_p1, sck_p2, mosi_p0, mosi_p1;
  logic [3:0]    bitcnt;
  logic [14:0]   shreg;
  logic [AW-1:0] waddr;
  logic          sck_rise;

  assign sck_rise = !cs_p1 && sck_p1 && !sck_p2;
  assign cpu_hold = !cs_p1;

  // ---- stage p0/p1: synchronizers; p2 gives the SCK edge detect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      sck_p0 <= 1'b0;
      sck_p1 <= 1'b0;
      sck_p2 <= 1'b0;
      bitcnt <= '0;
      waddr  <= '0;
      ld_we  <= 1'b0;
    end else begin
      cs_p0  <= nCS;
      cs_p1  <= cs_p0;
      sck_p0 <= SCK;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      ld_we  <= 1'b0;
      if (cs_p1) begin
        bitcnt <= '0;
        waddr  <= '0;
      end else if (sck_rise) begin
        bitcnt <= bitcnt + 4'd1;
        if (bitcnt == 4'd15) begin
          ld_we <= 1'b1;
          waddr <= waddr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mosi_p0 <= MOSI;
    mosi_p1 <= mosi_p0;
    if (sck_rise) begin
      shreg <= {shreg[13:0], mosi_p1};
      if (bitcnt == 4'd15) begin
        ld_data <= {shreg, mosi_p1};
        ld_addr <= waddr;
      end
    end
  end
`else
  logic unused_spi;
  assign unused_spi = ^{nCS, SCK, MOSI};
  assign cpu_hold   = 1'b0;
  assign ld_we      = 1'b0;
  assign ld_addr    = '0;
  assign ld_data    = '0;
`endif

endmodule

// File: tb/tb_forth_soc_top.sv
// Scoreboard bench for forth_soc_top: directed programs preloaded into iram,
// GPIO events checked by a monitor against a queue of expected pin states.
module tb_forth_soc_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        nCS, SCK, MOSI;
  wire  [15:0] pins;

  typedef struct {
    logic [31:0] obs;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [31:0] last_obs = 32'h0;

  logic [15:0] blink [18] = '{16'h8003, 16'h8101, 16'h0dc0, 16'h8002, 16'h8020, 16'h0840,
                              16'h600a, 16'h8001, 16'h01c0, 16'h4005, 16'h09c0, 16'h8003,
                              16'h04c0, 16'h0840, 16'h8100, 16'h0dc0, 16'h09c0, 16'h4004};

  // {a, b, sel, expected T} for "lit a; lit b; ALU sel with pop"
  logic [15:0] alu_tab [16][4] = '{
    '{16'd5, 16'd7, 16'd0,  16'h000C}, '{16'd5, 16'd7, 16'd1,  16'hFFFE},
    '{16'd6, 16'd3, 16'd2,  16'h0002}, '{16'd6, 16'd3, 16'd3,  16'h0007},
    '{16'd6, 16'd3, 16'd4,  16'h0005}, '{16'd5, 16'd7, 16'd5,  16'hFFF8},
    '{16'd5, 16'd0, 16'd6,  16'hFFFF}, '{16'd5, 16'd7, 16'd7,  16'hFFFF},
    '{16'd7, 16'd5, 16'd7,  16'h0000}, '{16'd1, 16'd6, 16'd8,  16'h0006},
    '{16'd1, 16'd6, 16'd9,  16'h0001}, '{16'd1, 16'd6, 16'd10, 16'h0003},
    '{16'd1, 16'd6, 16'd11, 16'h000C}, '{16'd2, 16'd0, 16'd12, 16'h8002},
    '{16'd1, 16'd6, 16'd14, 16'h0000}, '{16'd1, 16'd6, 16'd15, 16'h0005}};

  forth_soc_top #(.RAM_WORDS(256), .STACK_DEPTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .nCS  (nCS),
    .SCK  (SCK),
    .MOSI (MOSI),
    .pins (pins)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pin_state();
    return {dut.gpio_dir, pins & dut.gpio_dir};
  endfunction

  // Monitor: every change of the observable GPIO state pops one expectation
  initial begin : monitor
    exp_t        e;
    logic [31:0] cur;
    forever begin
      @(negedge clk);
      if (reset) last_cyc = 0;
      cur = pin_state();
      if (cur !== last_obs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pins_unexpected: got %h, required no change", cur);
        end else begin
          e = exp_q.pop_front();
          chk("pins", cur, e.obs);
          if (e.gap >= 0) chk("pins_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_obs = cur;
        last_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input logic [15:0] dir, input logic [15:0] lvl, input int gap);
    exp_t e;
    e.obs = {dir, lvl};
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Enters with reset high; loads three words, releases reset, runs ncyc edges
  task automatic run3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                      input int ncyc);
    dut.cpu_top.iram[0] <= w0;
    dut.cpu_top.iram[1] <= w1;
    dut.cpu_top.iram[2] <= w2;
    @(negedge clk);
    reset = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
  endtask

`ifdef SPI_LOADER_EN
  task automatic spi_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) begin
      MOSI = w[b];
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    nCS   = 1'b1;
    SCK   = 1'b0;
    MOSI  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_pc",  32'(dut.cpu_top.pc),  32'h0);
    chk("rst_t",   32'(dut.cpu_top.t),   32'h0);
    chk("rst_n",   32'(dut.cpu_top.n),   32'h0);
    chk("rst_r",   32'(dut.cpu_top.r),   32'h0);
    chk("rst_dsp", 32'(dut.cpu_top.dsp), 32'h0);
    chk("rst_rsp", 32'(dut.cpu_top.rsp), 32'h0);
    chk("rst_pins", pin_state(), 32'h0);

    for (int k = 0; k < 16; k++) begin
      run3(16'h8000 | alu_tab[k][0], 16'h8000 | alu_tab[k][1],
           16'h00c0 | (alu_tab[k][2] << 8), 3);
      chk($sformatf("alu_sel%0d", alu_tab[k][2]), 32'(dut.cpu_top.t), 32'(alu_tab[k][3]));
      reset = 1'b1;
    end

    run3(16'h8000, 16'h600a, 16'h0000, 2);
    chk("jz_taken_pc",  32'(dut.cpu_top.pc),  32'd10);
    chk("jz_taken_dsp", 32'(dut.cpu_top.dsp), 32'd0);
    chk("jz_taken_t",   32'(dut.cpu_top.t),   32'd0);
    reset = 1'b1;
    run3(16'h8001, 16'h600a, 16'h0000, 2);
    chk("jz_fall_pc",  32'(dut.cpu_top.pc),  32'd2);
    chk("jz_fall_dsp", 32'(dut.cpu_top.dsp), 32'd0);
    chk("jz_fall_t",   32'(dut.cpu_top.t),   32'd0);
    reset = 1'b1;

    dut.cpu_top.iram[5] <= 16'h8009;
    dut.cpu_top.iram[6] <= 16'h1830;
    run3(16'h2005, 16'h0000, 16'h0000, 1);
    chk("call_r",   32'(dut.cpu_top.r),   32'd1);
    chk("call_rsp", 32'(dut.cpu_top.rsp), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ret_pc",  32'(dut.cpu_top.pc),  32'd1);
    chk("ret_rsp", 32'(dut.cpu_top.rsp), 32'd0);
    chk("ret_t",   32'(dut.cpu_top.t),   32'd9);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) dut.cpu_top.iram[i] <= blink[i];
    push_exp(16'h0003, 16'h0000, 3);
    push_exp(16'h0003, 16'h0001, 170);
    push_exp(16'h0003, 16'h0002, 171);
    push_exp(16'h0003, 16'h0001, 171);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("store_t",   32'(dut.cpu_top.t),   32'h0102);
    chk("store_dsp", 32'(dut.cpu_top.dsp), 32'd1);
    wait_drain(1000, "blink");

    @(negedge clk);
    push_exp(16'h0000, 16'h0000, -1);
    reset = 1'b1;
    #1;
    chk("midrst_pc",  32'(dut.cpu_top.pc), 32'h0);
    chk("midrst_t",   32'(dut.cpu_top.t),  32'h0);
    chk("midrst_dir", 32'(dut.gpio_dir),   32'h0);
    chk("midrst_out", 32'(dut.gpio_out),   32'h0);
    repeat (3) @(negedge clk);
    push_exp(16'h0003, 16'h0000, 3);
    push_exp(16'h0003, 16'h0001, 170);
    reset = 1'b0;
    wait_drain(400, "restart");

`ifdef SPI_LOADER_EN
    @(negedge clk);
    push_exp(16'h0000, 16'h0000, -1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nCS = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    spi_word(16'h8003);
    chk("spi_hold_pc_a", 32'(dut.cpu_top.pc), 32'h0);
    spi_word(16'h8101);
    repeat (8) @(negedge clk);
    chk("spi_hold_pc_b", 32'(dut.cpu_top.pc), 32'h0);
    chk("spi_word0", 32'(dut.cpu_top.iram[0]), 32'h8003);
    chk("spi_word1", 32'(dut.cpu_top.iram[1]), 32'h8101);
    push_exp(16'h0003, 16'h0000, -1);
    nCS = 1'b1;
    repeat (4) @(negedge clk);
    chk("spi_word0_after", 32'(dut.cpu_top.iram[0]), 32'h8003);
    chk("spi_word1_after", 32'(dut.cpu_top.iram[1]), 32'h8101);
    wait_drain(50, "spi_run");
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
